sar_adc_scan_sequencer: RTL and testbench

//  Shares one sar_adc converter between NUM_CH analog channels. Drives the

---
 rtl/sar_seq_pkg.sv | 27 ++
 rtl/sar_adc_scan_sequencer_if.sv | 15 +
 rtl/sar_seq_next_ch.sv | 26 ++
 rtl/sar_adc_scan_sequencer.sv | 163 ++++++++++++++++
 tb/tb_sar_adc_scan_sequencer.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sar_seq_pkg.sv
// Shared types and sizing helpers for the SAR ADC scan sequencer.
package sar_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_START,
    S_WAIT,
    S_EMIT
  } state_e;

  localparam int DEF_N              = 8;
  localparam int DEF_NUM_CH         = 4;
  localparam int DEF_SETTLE_CYCLES  = 2;
  localparam int DEF_TIMEOUT_CYCLES = 64;

  // Width of a select/index bus; never below one bit even for tiny counts.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

  // Width of a counter that must be able to hold max_count.
  function automatic int cnt_width(input int max_count);
    return clog2_min1(max_count + 1);
  endfunction

endpackage

// File: rtl/sar_adc_scan_sequencer_if.sv
// Result stream: one tagged conversion result per valid/ready transfer.
interface sar_adc_scan_sequencer_if #(
  parameter int N  = 8,
  parameter int CW = 2
);

  logic          res_valid;
  logic          res_ready;
  logic [CW-1:0] res_ch;
  logic [N-1:0]  res_data;

  modport master (output res_valid, res_ch, res_data, input res_ready);
  modport slave  (input res_valid, res_ch, res_data, output res_ready);

endinterface

// File: rtl/sar_seq_next_ch.sv
// Finds the lowest set mask bit strictly above idx, or the lowest set bit
// overall when from_start is high (a search from index -1).
module sar_seq_next_ch #(
  parameter int NUM_CH = 4,
  parameter int CW     = 2
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [CW-1:0]     idx,
  input  logic              from_start,
  output logic [CW-1:0]     next_ch,
  output logic              found
);

  // Walking downwards lets the lowest qualifying bit be the last writer.
  always_comb begin
    next_ch = '0;
    found   = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (from_start || (i > int'(idx)))) begin
        next_ch = CW'(i);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sar_adc_scan_sequencer.sv
// Time-shares one SAR converter across NUM_CH mux channels and streams each
// result out tagged with its channel number.
module sar_adc_scan_sequencer
  import sar_seq_pkg::*;
#(
  parameter  int N              = DEF_N,
  parameter  int NUM_CH         = DEF_NUM_CH,
  parameter  int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter  int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int CW             = clog2_min1(NUM_CH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       scan_start,
  input  logic                       continuous,
  input  logic [NUM_CH-1:0]          ch_mask,
  output logic [CW-1:0]              adc_mux_sel,
  output logic                       adc_start,
  input  logic                       adc_done,
  input  logic [N-1:0]               adc_data,
  sar_adc_scan_sequencer_if.master   res,
  output logic                       busy,
  output logic                       scan_done,
  output logic                       err_timeout,
  input  logic                       err_clr
);

  localparam int SETTLE_LEN = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam int SW         = cnt_width(SETTLE_LEN);
  localparam int TW         = cnt_width(TIMEOUT_CYCLES);
  localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_LEN - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [CW-1:0]     ch_q, ch_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [CW-1:0]     res_ch_q;
  logic [N-1:0]      res_data_q;
  logic              capture, timeout, advance, done_pulse;

  logic [CW-1:0] first_ch, next_ch;
  logic          first_found, next_found;

  // Lowest enabled channel of the live mask: used for (re)latching a scan.
  sar_seq_next_ch #(.NUM_CH(NUM_CH), .CW(CW)) u_first (
    .mask       (ch_mask),
    .idx        ('0),
    .from_start (1'b1),
    .next_ch    (first_ch),
    .found      (first_found)
  );

  sar_seq_next_ch #(.NUM_CH(NUM_CH), .CW(CW)) u_next (
    .mask       (mask_q),
    .idx        (ch_q),
    .from_start (1'b0),
    .next_ch    (next_ch),
    .found      (next_found)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    state_d    = state_q;
    mask_d     = mask_q;
    ch_d       = ch_q;
    settle_d   = settle_q;
    timer_d    = timer_q;
    capture    = 1'b0;
    timeout    = 1'b0;
    advance    = 1'b0;
    done_pulse = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (scan_start && first_found) begin
          mask_d   = ch_mask;
          ch_d     = first_ch;
          settle_d = '0;
          state_d  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_q == SETTLE_LAST) state_d = S_START;
        else                         settle_d = settle_q + 1'b1;
      end
      S_START: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (adc_done) begin
          capture = 1'b1;
          state_d = S_EMIT;
        end else if (timer_q == TIMEOUT_LAST) begin
          timeout = 1'b1;
          advance = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_EMIT: begin
        if (res.res_ready) advance = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Shared exit from EMIT and from a timed-out WAIT.
    if (advance) begin
      settle_d = '0;
      if (next_found) begin
        ch_d    = next_ch;
        state_d = S_SETTLE;
      end else begin
        done_pulse = 1'b1;
        if (continuous && first_found) begin
          mask_d  = ch_mask;
          ch_d    = first_ch;
          state_d = S_SETTLE;
        end else begin
          state_d = S_IDLE;
        end
      end
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mask_q      <= '0;
      ch_q        <= '0;
      settle_q    <= '0;
      timer_q     <= '0;
      res_ch_q    <= '0;
      res_data_q  <= '0;
      scan_done   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      ch_q      <= ch_d;
      settle_q  <= settle_d;
      timer_q   <= timer_d;
      scan_done <= done_pulse;
      if (capture) begin
        res_ch_q   <= ch_q;
        res_data_q <= adc_data;
      end
      if (timeout)      err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;
    end
  end

  assign adc_mux_sel  = ch_q;
  assign adc_start    = (state_q == S_START);
  assign busy         = (state_q != S_IDLE);
  assign res.res_valid = (state_q == S_EMIT);
  assign res.res_ch   = res_ch_q;
  assign res.res_data = res_data_q;

endmodule

// File: tb/tb_sar_adc_scan_sequencer.sv
// Directed bench for sar_adc_scan_sequencer with the default parameters
// (N=8, NUM_CH=4, SETTLE_CYCLES=2, TIMEOUT_CYCLES=64).
module tb_sar_adc_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, scan_start, continuous, adc_done, err_clr;
  logic [3:0] ch_mask;
  logic [7:0] adc_data;
  logic [1:0] adc_mux_sel;
  logic       adc_start, busy, scan_done, err_timeout;

  int n_cmp = 0;
  int n_bad = 0;

  sar_adc_scan_sequencer_if #(.N(8), .CW(2)) res_if ();

  sar_adc_scan_sequencer #(
    .N(8), .NUM_CH(4), .SETTLE_CYCLES(2), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .scan_start  (scan_start),
    .continuous  (continuous),
    .ch_mask     (ch_mask),
    .adc_mux_sel (adc_mux_sel),
    .adc_start   (adc_start),
    .adc_done    (adc_done),
    .adc_data    (adc_data),
    .res         (res_if),
    .busy        (busy),
    .scan_done   (scan_done),
    .err_timeout (err_timeout),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
  endtask

  // Bounded wait until adc_start is seen in the current cycle.
  task automatic wait_for_start(input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (adc_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s_start_seen: adc_start not seen within 40 cycles", tag);
    end
  endtask

  // Called in the START cycle; answers delay cycles later, returns in EMIT.
  task automatic do_conv(input logic [7:0] data, input int delay);
    repeat (delay) tick();
    adc_done = 1'b1;
    adc_data = data;
    tick();
    adc_done = 1'b0;
    adc_data = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; scan_start = 1'b0; continuous = 1'b0; ch_mask = '0;
    adc_done = 1'b0; adc_data = '0; err_clr = 1'b0; res_if.res_ready = 1'b0;
    repeat (3) tick();
    n_cmp++; if ({busy, adc_start, res_if.res_valid, scan_done, err_timeout} !== 5'b0) begin n_bad++; $display("FAIL reset_flags: got %b want 00000", {busy, adc_start, res_if.res_valid, scan_done, err_timeout}); end
    n_cmp++; if ({adc_mux_sel, res_if.res_ch, res_if.res_data} !== 12'h0) begin n_bad++; $display("FAIL reset_buses: got %h want 000", {adc_mux_sel, res_if.res_ch, res_if.res_data}); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_single();
    bit ok_start = 1'b1;
    bit ok_valid = 1'b1;
    ch_mask = 4'b0100; continuous = 1'b0; res_if.res_ready = 1'b1;
    pulse_start();
    n_cmp++; if (adc_mux_sel !== 2'd2) begin n_bad++; $display("FAIL single_mux_cyc1: got %0d want 2", adc_mux_sel); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_cyc1: got %b want 1", busy); end
    for (int c = 1; c <= 11; c++) begin
      if (adc_start !== (c == 3)) ok_start = 1'b0;
      if (res_if.res_valid !== 1'b0) ok_valid = 1'b0;
      if (c == 11) begin adc_done = 1'b1; adc_data = 8'hA5; end
      tick();
    end
    adc_done = 1'b0; adc_data = '0;
    n_cmp++; if (!ok_start) begin n_bad++; $display("FAIL single_start_timing: adc_start not high at cycle 3 only"); end
    n_cmp++; if (!ok_valid) begin n_bad++; $display("FAIL single_early_valid: res_valid high before cycle 12"); end
    n_cmp++; if ({res_if.res_valid, res_if.res_ch, res_if.res_data} !== {1'b1, 2'd2, 8'hA5}) begin n_bad++; $display("FAIL single_result: got v=%b ch=%0d d=%h want v=1 ch=2 d=a5", res_if.res_valid, res_if.res_ch, res_if.res_data); end
    tick();
    n_cmp++; if ({res_if.res_valid, scan_done, busy} !== 3'b010) begin n_bad++; $display("FAIL single_end: got valid,done,busy=%b want 010", {res_if.res_valid, scan_done, busy}); end
    tick();
    n_cmp++; if (scan_done !== 1'b0) begin n_bad++; $display("FAIL single_done_pulse: scan_done=%b want 0", scan_done); end
  endtask

  task automatic test_continuous();
    logic [1:0] exp_ch [6] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
    logic [7:0] d;
    bit ok;
    ch_mask = 4'b1011; continuous = 1'b1; res_if.res_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      d = 8'h10 + 8'(i);
      wait_for_start("cont", ok);
      n_cmp++; if (adc_mux_sel !== exp_ch[i]) begin n_bad++; $display("FAIL cont_mux_%0d: got %0d want %0d", i, adc_mux_sel, exp_ch[i]); end
      if (i == 4) continuous = 1'b0;
      do_conv(d, 2);
      n_cmp++; if ({res_if.res_valid, res_if.res_ch, res_if.res_data} !== {1'b1, exp_ch[i], d}) begin n_bad++; $display("FAIL cont_result_%0d: got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h", i, res_if.res_valid, res_if.res_ch, res_if.res_data, exp_ch[i], d); end
      tick();
      n_cmp++; if (scan_done !== (exp_ch[i] == 2'd3)) begin n_bad++; $display("FAIL cont_scan_done_%0d: got %b want %b", i, scan_done, exp_ch[i] == 2'd3); end
      if (i == 2) begin
        n_cmp++; if ({busy, adc_mux_sel} !== {1'b1, 2'd0}) begin n_bad++; $display("FAIL cont_rescan: got busy=%b mux=%0d want busy=1 mux=0", busy, adc_mux_sel); end
      end
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL cont_stop: busy=%b want 0 after continuous dropped", busy); end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit hold_ok = 1'b1;
    ch_mask = 4'b0011; continuous = 1'b0; res_if.res_ready = 1'b0;
    pulse_start();
    ch_mask = 4'b1000;
    wait_for_start("bp", ok);
    do_conv(8'h3C, 3);
    for (int k = 0; k < 5; k++) begin
      if ({res_if.res_valid, res_if.res_ch, res_if.res_data, adc_start} !== {1'b1, 2'd0, 8'h3C, 1'b0}) hold_ok = 1'b0;
      tick();
    end
    n_cmp++; if (!hold_ok) begin n_bad++; $display("FAIL bp_hold: result not held stable or adc_start seen while stalled"); end
    n_cmp++; if ({res_if.res_valid, res_if.res_data} !== {1'b1, 8'h3C}) begin n_bad++; $display("FAIL bp_still_valid: got v=%b d=%h want v=1 d=3c", res_if.res_valid, res_if.res_data); end
    res_if.res_ready = 1'b1;
    tick();
    n_cmp++; if ({res_if.res_valid, adc_mux_sel} !== {1'b0, 2'd1}) begin n_bad++; $display("FAIL bp_after_xfer: got v=%b mux=%0d want v=0 mux=1", res_if.res_valid, adc_mux_sel); end
    wait_for_start("bp2", ok);
    do_conv(8'h5A, 1);
    n_cmp++; if ({res_if.res_ch, res_if.res_data} !== {2'd1, 8'h5A}) begin n_bad++; $display("FAIL bp_second: got ch=%0d d=%h want ch=1 d=5a", res_if.res_ch, res_if.res_data); end
    tick();
    n_cmp++; if ({scan_done, busy} !== 2'b10) begin n_bad++; $display("FAIL bp_mask_latched: got done,busy=%b want 10 (ch3 must not run)", {scan_done, busy}); end
  endtask

  task automatic test_timeout();
    bit ok;
    bit no_valid = 1'b1;
    ch_mask = 4'b0101; continuous = 1'b0; res_if.res_ready = 1'b1;
    pulse_start();
    wait_for_start("to", ok);
    for (int k = 1; k <= 65; k++) begin
      tick();
      if (res_if.res_valid !== 1'b0) no_valid = 1'b0;
      if (k == 63) begin
        n_cmp++; if (err_timeout !== 1'b0) begin n_bad++; $display("FAIL to_early: err_timeout=%b want 0 at start+63", err_timeout); end
      end
    end
    n_cmp++; if (err_timeout !== 1'b1) begin n_bad++; $display("FAIL to_set: err_timeout=%b want 1 at start+65", err_timeout); end
    n_cmp++; if (!no_valid) begin n_bad++; $display("FAIL to_no_result: res_valid seen after timeout"); end
    n_cmp++; if (adc_mux_sel !== 2'd2) begin n_bad++; $display("FAIL to_next_ch: mux=%0d want 2", adc_mux_sel); end
    wait_for_start("to2", ok);
    do_conv(8'h77, 1);
    n_cmp++; if ({res_if.res_ch, res_if.res_data, err_timeout} !== {2'd2, 8'h77, 1'b1}) begin n_bad++; $display("FAIL to_sticky: got ch=%0d d=%h err=%b want ch=2 d=77 err=1", res_if.res_ch, res_if.res_data, err_timeout); end
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_cmp++; if (err_timeout !== 1'b0) begin n_bad++; $display("FAIL to_clear: err_timeout=%b want 0", err_timeout); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    ch_mask = 4'b0010; continuous = 1'b0; res_if.res_ready = 1'b1;
    pulse_start();
    wait_for_start("rst", ok);
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    n_cmp++; if ({busy, adc_start, res_if.res_valid, scan_done, err_timeout} !== 5'b0) begin n_bad++; $display("FAIL rst_mid_flags: got %b want 00000", {busy, adc_start, res_if.res_valid, scan_done, err_timeout}); end
    n_cmp++; if ({adc_mux_sel, res_if.res_ch, res_if.res_data} !== 12'h0) begin n_bad++; $display("FAIL rst_mid_buses: got %h want 000", {adc_mux_sel, res_if.res_ch, res_if.res_data}); end
    rst_n = 1'b1;
    adc_done = 1'b1; adc_data = 8'hEE;
    tick();
    adc_done = 1'b0; adc_data = '0;
    tick();
    n_cmp++; if ({busy, res_if.res_valid, res_if.res_data} !== 10'h0) begin n_bad++; $display("FAIL rst_stray_done: got busy=%b v=%b d=%h want 0 0 00", busy, res_if.res_valid, res_if.res_data); end
  endtask

  task automatic test_ignored_start();
    bit ok;
    bit idle_ok = 1'b1;
    ch_mask = 4'b0000; continuous = 1'b0; res_if.res_ready = 1'b1;
    pulse_start();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL empty_mask_busy: busy=%b want 0", busy); end
    tick();
    n_cmp++; if (scan_done !== 1'b0) begin n_bad++; $display("FAIL empty_mask_done: scan_done=%b want 0", scan_done); end
    ch_mask = 4'b0001;
    pulse_start();
    ch_mask = 4'b1000;
    pulse_start();
    wait_for_start("busy", ok);
    n_cmp++; if (adc_mux_sel !== 2'd0) begin n_bad++; $display("FAIL busy_start_mux: got %0d want 0", adc_mux_sel); end
    do_conv(8'h42, 2);
    n_cmp++; if ({res_if.res_ch, res_if.res_data} !== {2'd0, 8'h42}) begin n_bad++; $display("FAIL busy_start_result: got ch=%0d d=%h want ch=0 d=42", res_if.res_ch, res_if.res_data); end
    tick();
    n_cmp++; if ({scan_done, busy} !== 2'b10) begin n_bad++; $display("FAIL busy_start_end: got done,busy=%b want 10", {scan_done, busy}); end
    for (int k = 0; k < 4; k++) begin
      tick();
      if (busy !== 1'b0) idle_ok = 1'b0;
    end
    n_cmp++; if (!idle_ok) begin n_bad++; $display("FAIL busy_start_queued: a scan_start given while busy took effect"); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_continuous();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_ignored_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
